johnson_seq_ctrl: RTL and testbench
===================================

JOHNSON_SEQ_CTRL -- requirements
Module: johnson_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 4: Johnson ring width; 2N states per revolution.
REQ-002 SHALL have parameter CW, default 8: width of revolution counters.
REQ-003 SHALL have this clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request a run; sampled only in IDLE.
REQ-007 dir  in  1  0=forward, 1=reverse; latched on accepted start.
REQ-008 num_cycles  in  CW  revolutions to run; latched on accepted start.
REQ-009 pause  in  1  freezes ring and counters while high in RUN.
REQ-010 stop  in  1  request early termination at the next revolution boundary.
REQ-011 phase  out  N  current Johnson ring state.
REQ-012 rev_cnt  out  CW  revolutions completed since last accepted start.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 done  out  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE->RUN when start=1 and num_cycles!=0; on that edge: latch dir and num_cycles into remaining-count, clear rev_cnt and stop_pending; phase stays all-zero.
REQ-017 start with num_cycles=0 SHALL be ignored: remain IDLE, no done.
REQ-018 start while busy SHALL be ignored; dir/num_cycles changes during a run have no effect.
REQ-019 Forward step: phase <= {phase[N-2:0], ~phase[N-1]}; N=4 sequence 0000,0001,0011,0111,1111,1110,1100,1000,0000.
REQ-020 Reverse step: phase <= {~phase[0], phase[N-1:1]}; N=4 sequence 0000,1000,1100,1110,1111,0111,0011,0001,0000.
REQ-021 In RUN with pause=0, phase SHALL advance exactly one step per clock; no advance in IDLE or DONE.
REQ-022 Revolution boundary = a step whose result is all-zero; on it rev_cnt increments and remaining-count decrements.
REQ-023 RUN->DONE on the boundary step where remaining-count becomes 0, or on the boundary step when stop_pending=1; num_cycles=k SHALL give exactly 2N*k steps with no stop.
REQ-024 stop=1 in RUN SHALL set stop_pending (sticky until next accepted start); stepping continues to the next boundary.
REQ-025 stop while in RUN with phase all-zero and no step yet taken SHALL move RUN->DONE on the next edge without stepping; rev_cnt stays 0.
REQ-026 pause and stop both high: pause wins for stepping, stop is still latched.
REQ-027 DONE SHALL last exactly one cycle with done=1, busy=1, then IDLE; phase is all-zero in DONE.
REQ-028 rev_cnt SHALL hold its final value in IDLE until the next accepted start; wraps modulo 2^CW.
REQ-029 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-030 rst=0 SHALL asynchronously force state IDLE, phase=0, rev_cnt=0, remaining-count=0, stop_pending=0, dir latch=0, busy=0, done=0.
REQ-031 Reset asserted mid-run SHALL abort without a done pulse; after release, block idles until a new start.

Structure
REQ-032 Shared package johnson_pkg SHALL hold FSM state enum and default N/CW constants.
REQ-033 Ring register SHALL be a sub-module johnson_ring (ports clk, rst, en, dir, phase); controller drives en.

Verification
REQ-034 N=4, start, num_cycles=1, dir=0 -> forward sequence over 8 clocks, done pulse 1 cycle after 8th step, rev_cnt=1.
REQ-035 num_cycles=3, dir=1 -> 24 reverse steps, rev_cnt 1,2,3 at boundaries, single done, busy high throughout.
REQ-036 num_cycles=5, stop at phase 0111 in rev 2 -> continue to 0000, done, rev_cnt=2; start with num_cycles=0 -> no busy, no done.
REQ-037 pause high 3 cycles at phase 0011 -> phase and rev_cnt frozen, run length extended by exactly 3 cycles.
REQ-038 rst low at phase 1110 mid-run -> all outputs to reset values immediately, no done; new start runs normally.
REQ-039 start pulsed while busy and dir toggled mid-run -> ignored, sequence and done timing unchanged.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson-ring sequence controller: controller
// state encoding and the default ring/counter widths.
package johnson_pkg;

  // Default Johnson ring width (2*N states per revolution).
  localparam int unsigned DEF_N  = 4;

  // Default width of the revolution and remaining-count counters.
  localparam int unsigned DEF_CW = 8;

  // Controller states: idle, stepping the ring, one-cycle completion.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/johnson_ring.sv
// N-bit Johnson (twisted-ring) counter. It advances one step per enabled
// clock, either forward (shifting toward the MSB) or in reverse (shifting
// toward the LSB). Both directions visit the same 2*N states.
module johnson_ring
  import johnson_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         dir,
  output logic [N-1:0] phase
);

  // Advance one Johnson step when enabled; hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so that every
    // register samples the values from before the edge.
    if (!rst) begin
      phase <= '0;
    end else if (en) begin
      if (dir) begin
        phase <= {~phase[0], phase[N-1:1]};
      end else begin
        phase <= {phase[N-2:0], ~phase[N-1]};
      end
    end
  end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Johnson-ring sequence controller. An accepted start runs the ring for a
// programmed number of revolutions in a latched direction. The run can be
// paused, or cut short at the next revolution boundary by stop. DONE gives
// a one-cycle completion pulse. Every output comes straight from a flop.
module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          dir,
  input  logic [CW-1:0] num_cycles,
  input  logic          pause,
  input  logic          stop,
  output logic [N-1:0]  phase,
  output logic [CW-1:0] rev_cnt,
  output logic          busy,
  output logic          done
);

  // Last ring state before a wrap to all-zero, in each direction.
  localparam logic [N-1:0] FWD_LAST = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] REV_LAST = {{(N-1){1'b0}}, 1'b1};

  state_t        state, state_n;
  logic          dir_q;
  logic          stop_pending;
  logic          stepped;
  logic [CW-1:0] remaining;

  logic          accept;
  logic          run_live;
  logic          at_origin;
  logic          early_stop;
  logic          step;
  logic          boundary;
  logic          finish;

  johnson_ring #(
    .N (N)
  ) u_ring (
    .clk   (clk),
    .rst   (rst),
    .en    (step),
    .dir   (dir_q),
    .phase (phase)
  );

  // Next-state and step decisions for the controller.
  always_comb begin
    // NOTE: every variable gets a default before any branch; otherwise a
    // path that skips an assignment would infer a latch.
    state_n    = state;
    accept     = 1'b0;
    run_live   = 1'b0;
    at_origin  = 1'b0;
    early_stop = 1'b0;
    step       = 1'b0;
    boundary   = 1'b0;
    finish     = 1'b0;

    accept    = (state == ST_IDLE) && start && (num_cycles != '0);
    run_live  = (state == ST_RUN) && !pause;
    // Still at the start of the run: no step taken and the ring at zero.
    at_origin = !stepped && (phase == '0);
    // A stop before the first step ends the run without touching the ring.
    early_stop = run_live && at_origin && (stop || stop_pending);
    step       = run_live && !early_stop;
    boundary   = step && (phase == (dir_q ? REV_LAST : FWD_LAST));
    finish     = early_stop ||
                 (boundary && ((remaining == CW'(1)) || stop_pending || stop));

    case (state)
      ST_IDLE: if (accept) state_n = ST_RUN;
      ST_RUN:  if (finish) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State register plus the registered busy/done flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != ST_IDLE);
      done  <= (state_n == ST_DONE);
    end
  end

  // Run context: direction latch, counters, stop request, first-step flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q        <= 1'b0;
      remaining    <= '0;
      rev_cnt      <= '0;
      stop_pending <= 1'b0;
      stepped      <= 1'b0;
    end else if (accept) begin
      dir_q        <= dir;
      remaining    <= num_cycles;
      rev_cnt      <= '0;
      stop_pending <= 1'b0;
      stepped      <= 1'b0;
    end else begin
      // A stop is latched even while paused; it takes effect at a boundary.
      if ((state == ST_RUN) && stop) begin
        stop_pending <= 1'b1;
      end
      if (step) begin
        stepped <= 1'b1;
      end
      if (boundary) begin
        rev_cnt   <= rev_cnt + CW'(1);
        remaining <= remaining - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Self-checking bench for johnson_seq_ctrl (N=4, CW=8). Each applied vector
// pushes its expected outputs to a scoreboard queue before the clock edge.
// The entry is popped and compared #1 after the edge.
module tb_johnson_seq_ctrl;

  localparam int N  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic [CW-1:0] num_cycles = '0;
  logic          pause = 1'b0;
  logic          stop = 1'b0;
  logic [N-1:0]  phase;
  logic [CW-1:0] rev_cnt;
  logic          busy;
  logic          done;

  typedef struct packed {
    logic [N-1:0]  phase;
    logic [CW-1:0] rev;
    logic          busy;
    logic          done;
  } out_t;

  typedef struct {
    logic          start;
    logic          dir;
    logic [CW-1:0] num;
    logic          pause;
    logic          stop;
    out_t          exp;
  } vec_t;

  out_t         sb[$];
  int           vectors = 0;
  int           miscompares = 0;
  logic [N-1:0] fwd_seq[8];
  logic [N-1:0] rev_seq[8];
  vec_t         tbl[12];

  always #5 clk = ~clk;

  johnson_seq_ctrl #(
    .N  (N),
    .CW (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dir        (dir),
    .num_cycles (num_cycles),
    .pause      (pause),
    .stop       (stop),
    .phase      (phase),
    .rev_cnt    (rev_cnt),
    .busy       (busy),
    .done       (done)
  );

  function automatic out_t mko(logic [N-1:0] ph, logic [CW-1:0] r, logic b, logic d);
    out_t o;
    o.phase = ph;
    o.rev   = r;
    o.busy  = b;
    o.done  = d;
    return o;
  endfunction

  function automatic vec_t mkv(logic s, logic d, logic [CW-1:0] n, logic p, logic st, out_t e);
    vec_t v;
    v.start = s;
    v.dir   = d;
    v.num   = n;
    v.pause = p;
    v.stop  = st;
    v.exp   = e;
    return v;
  endfunction

  // Pop the oldest expectation and compare it with the live outputs.
  task automatic check(input string name);
    out_t got;
    out_t e;
    got = {phase, rev_cnt, busy, done};
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty at t=%0t", name, $time);
      return;
    end
    e = sb.pop_front();
    if (got !== e) begin
      miscompares++;
      $display("FAIL %s (t=%0t): got phase=%b rev_cnt=%0d busy=%b done=%b, expected phase=%b rev_cnt=%0d busy=%b done=%b",
               name, $time, got.phase, got.rev, got.busy, got.done,
               e.phase, e.rev, e.busy, e.done);
    end
  endtask

  // Drive one vector at the falling edge, clock it, then check.
  task automatic apply(input string name, input vec_t v);
    start      = v.start;
    dir        = v.dir;
    num_cycles = v.num;
    pause      = v.pause;
    stop       = v.stop;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    check(name);
    @(negedge clk);
  endtask

  // A complete run of k revolutions with closed-form expectations. With
  // noise set, start is pulsed and dir/num_cycles wiggle during the run.
  task automatic run_clean(input string name, input logic d, input logic [CW-1:0] k, input bit noise);
    int total;
    total = 8 * int'(k);
    apply(name, mkv(1'b1, d, k, 1'b0, 1'b0, mko('0, '0, 1'b1, 1'b0)));
    for (int i = 1; i <= total; i++) begin
      logic [N-1:0] ph;
      logic         s_n;
      logic         d_n;
      ph  = d ? rev_seq[i % 8] : fwd_seq[i % 8];
      s_n = noise && (i % 5 == 0);
      d_n = noise ? logic'(i % 2) : d;
      apply(name, mkv(s_n, d_n, noise ? CW'(9) : k, 1'b0, 1'b0,
                      mko(ph, CW'(i / 8), 1'b1, i == total)));
    end
    apply(name, mkv(1'b0, d, k, 1'b0, 1'b0, mko('0, k, 1'b0, 1'b0)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fwd_seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    rev_seq = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};

    // One forward revolution, then a zero-length start that must be ignored.
    tbl[0]  = mkv(1'b1, 1'b0, 8'd1, 1'b0, 1'b0, mko(4'b0000, 8'd0, 1'b1, 1'b0));
    tbl[1]  = mkv(1'b0, 1'b0, 8'd1, 1'b0, 1'b0, mko(4'b0001, 8'd0, 1'b1, 1'b0));
    tbl[2]  = mkv(1'b0, 1'b0, 8'd1, 1'b0, 1'b0, mko(4'b0011, 8'd0, 1'b1, 1'b0));
    tbl[3]  = mkv(1'b0, 1'b0, 8'd1, 1'b0, 1'b0, mko(4'b0111, 8'd0, 1'b1, 1'b0));
    tbl[4]  = mkv(1'b0, 1'b0, 8'd1, 1'b0, 1'b0, mko(4'b1111, 8'd0, 1'b1, 1'b0));
    tbl[5]  = mkv(1'b0, 1'b0, 8'd1, 1'b0, 1'b0, mko(4'b1110, 8'd0, 1'b1, 1'b0));
    tbl[6]  = mkv(1'b0, 1'b0, 8'd1, 1'b0, 1'b0, mko(4'b1100, 8'd0, 1'b1, 1'b0));
    tbl[7]  = mkv(1'b0, 1'b0, 8'd1, 1'b0, 1'b0, mko(4'b1000, 8'd0, 1'b1, 1'b0));
    tbl[8]  = mkv(1'b0, 1'b0, 8'd1, 1'b0, 1'b0, mko(4'b0000, 8'd1, 1'b1, 1'b1));
    tbl[9]  = mkv(1'b0, 1'b0, 8'd1, 1'b0, 1'b0, mko(4'b0000, 8'd1, 1'b0, 1'b0));
    tbl[10] = mkv(1'b1, 1'b1, 8'd0, 1'b0, 1'b0, mko(4'b0000, 8'd1, 1'b0, 1'b0));
    tbl[11] = mkv(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, mko(4'b0000, 8'd1, 1'b0, 1'b0));

    // Reset state.
    repeat (2) @(negedge clk);
    sb.push_back(mko('0, '0, 1'b0, 1'b0));
    check("reset_state");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      apply("fwd_table", tbl[i]);
    end

    // Three reverse revolutions; start pulses and dir toggles are ignored.
    run_clean("rev3_noise", 1'b1, 8'd3, 1'b1);

    // Stop while at 0111 in the second revolution: finish at the next zero.
    apply("stop_mid", mkv(1'b1, 1'b0, 8'd5, 1'b0, 1'b0, mko('0, '0, 1'b1, 1'b0)));
    for (int i = 1; i <= 16; i++) begin
      apply("stop_mid", mkv(1'b0, 1'b0, 8'd5, 1'b0, i == 12,
                            mko(fwd_seq[i % 8], CW'(i / 8), 1'b1, i == 16)));
    end
    apply("stop_mid", mkv(1'b0, 1'b0, 8'd5, 1'b0, 1'b0, mko('0, 8'd2, 1'b0, 1'b0)));

    // Pause for three cycles at 0011: everything frozen, run three longer.
    begin
      int s;
      s = 0;
      apply("pause3", mkv(1'b1, 1'b0, 8'd1, 1'b0, 1'b0, mko('0, '0, 1'b1, 1'b0)));
      for (int c = 1; c <= 11; c++) begin
        logic p;
        p = (c >= 3) && (c <= 5);
        if (!p) s++;
        apply("pause3", mkv(1'b0, 1'b0, 8'd1, p, 1'b0,
                            mko(fwd_seq[s % 8], CW'(s / 8), 1'b1, (s == 8) && !p)));
      end
      apply("pause3", mkv(1'b0, 1'b0, 8'd1, 1'b0, 1'b0, mko('0, 8'd1, 1'b0, 1'b0)));
    end

    // Pause and stop together: no stepping, but stop is latched.
    begin
      int s;
      s = 0;
      apply("pause_stop", mkv(1'b1, 1'b0, 8'd2, 1'b0, 1'b0, mko('0, '0, 1'b1, 1'b0)));
      for (int c = 1; c <= 10; c++) begin
        logic p;
        p = (c == 4) || (c == 5);
        if (!p) s++;
        apply("pause_stop", mkv(1'b0, 1'b0, 8'd2, p, p,
                                mko(fwd_seq[s % 8], CW'(s / 8), 1'b1, (s == 8) && !p)));
      end
      apply("pause_stop", mkv(1'b0, 1'b0, 8'd2, 1'b0, 1'b0, mko('0, 8'd1, 1'b0, 1'b0)));
    end

    // Stop before the first step: straight to DONE, rev_cnt stays 0.
    apply("early_stop", mkv(1'b1, 1'b0, 8'd3, 1'b0, 1'b0, mko('0, '0, 1'b1, 1'b0)));
    apply("early_stop", mkv(1'b0, 1'b0, 8'd3, 1'b0, 1'b1, mko('0, '0, 1'b1, 1'b1)));
    apply("early_stop", mkv(1'b0, 1'b0, 8'd3, 1'b0, 1'b0, mko('0, '0, 1'b0, 1'b0)));

    // Reset asserted mid-run at phase 1110.
    apply("rst_run", mkv(1'b1, 1'b0, 8'd2, 1'b0, 1'b0, mko('0, '0, 1'b1, 1'b0)));
    for (int i = 1; i <= 5; i++) begin
      apply("rst_run", mkv(1'b0, 1'b0, 8'd2, 1'b0, 1'b0,
                           mko(fwd_seq[i], '0, 1'b1, 1'b0)));
    end
    #2 rst = 1'b0;
    #1;
    sb.push_back(mko('0, '0, 1'b0, 1'b0));
    check("rst_async");
    @(negedge clk);
    sb.push_back(mko('0, '0, 1'b0, 1'b0));
    check("rst_hold");
    rst = 1'b1;
    apply("rst_idle", mkv(1'b0, 1'b0, 8'd2, 1'b0, 1'b0, mko('0, '0, 1'b0, 1'b0)));
    apply("rst_idle", mkv(1'b0, 1'b0, 8'd2, 1'b0, 1'b0, mko('0, '0, 1'b0, 1'b0)));
    run_clean("after_rst", 1'b0, 8'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
